// File: rtl/req_ack_arbiter.sv
// -----------------------------------------------------------------------------
// req_ack_arbiter
//
// Round-robin arbiter that shares one fixed-latency acknowledge responder
// among N requesters. A 0->1 transition on req[i] queues a pending request
// for channel i. Requests are served one at a time. Each served request
// spends ACK_DELAY cycles in SERVE and then gets a one-cycle ack pulse on its
// own channel.
//
// Parameters
//   N          number of requesters (2..8)
//   ACK_DELAY  cycles spent in SERVE before the ack cycle (>= 1)
//   IDW        width of grant_id (2**IDW >= N)
//
// Ports
//   clk        single clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   req        per-channel request level; a rising edge is one request
//   ack        one-hot, one-cycle acknowledge for the served channel
//   busy       high while a request is in SERVE or ACK
//   grant_id   index of the channel being served; holds its value when idle
//   overrun    one-cycle pulse when a channel's new edge is dropped
// -----------------------------------------------------------------------------
module req_ack_arbiter #(
  parameter int N         = 4,
  parameter int ACK_DELAY = 5,
  parameter int IDW       = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [IDW-1:0] grant_id,
  output logic [N-1:0]   overrun
);

  // The counter only has to reach ACK_DELAY-1; keep it at least one bit wide.
  localparam int CW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(ACK_DELAY - 1);
  localparam logic [IDW-1:0] LAST_RESET = IDW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [IDW-1:0] grant_id_reg, grant_id_next;
  logic [IDW-1:0] last_reg, last_next;

  logic [N-1:0]   req_d1_reg;
  logic [N-1:0]   pos_edge;
  logic [N-1:0]   pending_reg, pending_next;
  logic [N-1:0]   clr_mask;
  logic [N-1:0]   overrun_reg, overrun_next;
  logic [N-1:0]   ack_reg, ack_next;
  logic           busy_reg, busy_next;

  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_id;

  // Channel index reached by stepping k positions past base, modulo N.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-channel edge detect, pending bookkeeping and overrun detection
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign pos_edge[gi] = req[gi] & ~req_d1_reg[gi];

      // The channel whose ACK cycle is in progress has its pending bit retired.
      assign clr_mask[gi] = (state_reg == ST_ACK) && (grant_id_reg == IDW'(gi));

      // A new edge always sets the bit, even while it is being cleared, so an
      // edge in the channel's own ACK cycle re-queues it.
      assign pending_next[gi] = pos_edge[gi] | (pending_reg[gi] & ~clr_mask[gi]);

      // An edge is lost only if a request is already queued and not retiring.
      assign overrun_next[gi] = pos_edge[gi] & pending_reg[gi] & ~clr_mask[gi];

      assign ack_next[gi] = (state_next == ST_ACK) && (grant_id_next == IDW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration candidates
  // ---------------------------------------------------------------------------
  // Fresh edges are normally not visible to arbitration until they land in
  // pending_reg. The exception is the channel in its own ACK cycle: its stale
  // pending bit is masked off and replaced by its re-queue edge, so a re-queued
  // request is served back-to-back without an idle gap.
  always_comb begin
    cand = pending_reg;
    if (state_reg == ST_ACK) begin
      cand = (pending_reg & ~clr_mask) | (pos_edge & clr_mask);
    end
  end

  // Round-robin search starting at last+1; last itself is checked at the end.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && cand[rr_index(last_reg, k)]) begin
        win_found = 1'b1;
        win_id    = rr_index(last_reg, k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Service FSM: next state, counter and grant bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    grant_id_next = grant_id_reg;
    last_next     = last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          state_next    = ST_SERVE;
          count_next    = '0;
          grant_id_next = win_id;
          last_next     = win_id;
        end
      end

      ST_SERVE: begin
        if (count_reg == COUNT_LAST) begin
          state_next = ST_ACK;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      ST_ACK: begin
        if (win_found) begin
          state_next    = ST_SERVE;
          count_next    = '0;
          grant_id_next = win_id;
          last_next     = win_id;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  assign busy_next = (state_next != ST_IDLE);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      grant_id_reg <= '0;
      last_reg     <= LAST_RESET;
      req_d1_reg   <= '0;
      pending_reg  <= '0;
      overrun_reg  <= '0;
      ack_reg      <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      grant_id_reg <= grant_id_next;
      last_reg     <= last_next;
      req_d1_reg   <= req;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
      ack_reg      <= ack_next;
      busy_reg     <= busy_next;
    end
  end

  assign ack      = ack_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_req_ack_arbiter
//
// Directed testbench for req_ack_arbiter (N=4, ACK_DELAY=5, IDW=2). Each
// scenario drives req levels and compares ack / overrun / busy / grant_id
// cycle by cycle against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_req_ack_arbiter;

  localparam int N         = 4;
  localparam int ACK_DELAY = 5;
  localparam int IDW       = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   overrun;

  int n_cmp;
  int n_err;

  req_ack_arbiter #(
    .N         (N),
    .ACK_DELAY (ACK_DELAY),
    .IDW       (IDW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Step ncyc cycles. The ack expected after the c-th edge is aa when c==ta,
  // ab when c==tb, and zero otherwise. overrun must stay zero throughout.
  task automatic watch(input string tag, input int ncyc,
                       input int ta, input logic [N-1:0] aa,
                       input int tb, input logic [N-1:0] ab);
    logic [N-1:0] e;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      e = (c == ta) ? aa : ((c == tb) ? ab : '0);
      check($sformatf("%s ack c%0d", tag, c), 32'(ack), 32'(e));
      check($sformatf("%s overrun c%0d", tag, c), 32'(overrun), 32'h0);
      if (e != '0) begin
        check($sformatf("%s grant c%0d", tag, c), 32'(grant_id),
              32'(onehot_idx(e)));
        $display("%s: c%0d ack=%b grant_id=%0d", tag, c, ack, grant_id);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    req   = '0;

    // ---------------- reset state ----------------
    do_reset();
    check("reset ack", 32'(ack), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset grant", 32'(grant_id), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    $display("reset: ack=%b busy=%b grant_id=%0d", ack, busy, grant_id);

    // ---------------- single request ----------------
    // Edge sampled at c=1 (E0); busy after E1..E6; ack after E6 (c=7).
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check($sformatf("single ack c%0d", c), 32'(ack),
            (c == 7) ? 32'h1 : 32'h0);
      check($sformatf("single busy c%0d", c), 32'(busy),
            (c >= 2 && c <= 7) ? 32'h1 : 32'h0);
      if (c == 7) check("single grant", 32'(grant_id), 32'h0);
    end
    $display("single: request on ch0 served");

    // ---------------- simultaneous requests ----------------
    do_reset();
    req = 4'b0101;
    watch("simul", 20, 7, 4'b0001, 13, 4'b0100);
    check("simul grant held", 32'(grant_id), 32'h2);
    check("simul busy idle", 32'(busy), 32'h0);

    // ---------------- round-robin fairness ----------------
    // First serve ch1 alone so that the last grant is 1.
    do_reset();
    req = 4'b0010;
    watch("rr prime", 9, 7, 4'b0010, -1, '0);
    for (int r = 0; r < 2; r++) begin
      req = '0;
      tick();
      tick();
      req = 4'b1010;
      watch($sformatf("rr round%0d", r), 18, 7, 4'b1000, 13, 4'b0010);
    end

    // ---------------- overrun ----------------
    do_reset();
    req = 4'b0100;
    tick();                       // E0: ch2 edge
    tick();                       // E1: SERVE ch2
    req = 4'b0110;
    tick();                       // E2: ch1 edge, queued
    check("ovr E2", 32'(overrun), 32'h0);
    req = 4'b0100;
    tick();                       // E3
    check("ovr E3", 32'(overrun), 32'h0);
    req = 4'b0110;
    tick();                       // E4: second ch1 edge, dropped
    check("ovr E4", 32'(overrun), 32'h2);
    $display("overrun: overrun=%b after second ch1 edge", overrun);
    tick();                       // E5
    check("ovr E5", 32'(overrun), 32'h0);
    watch("ovr serve", 14, 1, 4'b0100, 7, 4'b0010);

    // ---------------- re-queue on own ack ----------------
    do_reset();
    req = 4'b0001;
    tick();                       // E0
    req = 4'b0000;
    watch("requeue first", 6, 6, 4'b0001, -1, '0);
    req = 4'b0001;                // edge sampled in the ACK cycle
    watch("requeue second", 9, 6, 4'b0001, -1, '0);

    // ---------------- reset mid-SERVE ----------------
    do_reset();
    req = 4'b0001;
    watch("abort pre", 5, -1, '0, -1, '0);   // E0..E4, count=3 after E4
    check("abort busy pre", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort rst ack", 32'(ack), 32'h0);
    check("abort rst busy", 32'(busy), 32'h0);
    check("abort rst grant", 32'(grant_id), 32'h0);
    watch("abort post", 10, 7, 4'b0001, -1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/req_ack_arbiter.md
# req_ack_arbiter

Round-robin arbiter that shares a single fixed-latency request/acknowledge responder among N requesters. Each requester signals with a rising edge on its level `req` line. The arbiter queues the edge as a pending request and serves requests one at a time. Each served request gets a one-cycle `ack` pulse on its own channel a fixed number of cycles after it is granted. The block sits between the requesting agents and the shared acknowledge resource and replaces per-agent private edge-to-ack delay logic.

## Interface

- `N`, 4, number of requesters (2..8).
- `ACK_DELAY`, 5, cycles spent in SERVE before the ack cycle (≥1).
- `IDW`, 2, width of `grant_id`; must satisfy 2^IDW ≥ N.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: per-channel request level; a 0→1 transition is one request.
- `ack` output N: one-hot, one-cycle acknowledge pulse for the served channel.
- `busy` output 1: high while a request is in SERVE or ACK.
- `grant_id` output IDW: index of the channel currently served; holds its last value when idle.
- `overrun` output N: one-cycle pulse when a channel's new edge is dropped.

## Operation

- **Edge detect, per channel.**
  - `req_d1[i]` is a register of `req[i]`.
  - `pos_edge[i] = req[i] & ~req_d1[i]`, combinational.
- **Pending bit, per channel.**
  - `pos_edge[i]` sets `pending[i]`.
  - The ACK cycle of channel i clears `pending[i]`.
  - Set wins over clear: an edge during channel i's own ACK cycle re-queues it.
- **Overrun.**
  - An edge on channel i while `pending[i]` is already 1 and not being cleared is dropped.
  - Registered `overrun[i]` pulses high for one cycle.
- **FSM, states IDLE, SERVE, ACK.**
  - IDLE: if any `pending` bit is set, go to SERVE. Load `grant_id` with the winner and load count=0. Otherwise stay.
  - SERVE: count increments each cycle. When count == ACK_DELAY-1, go to ACK.
  - ACK: `ack[grant_id]`=1 and `pending[grant_id]` clears.
    - If any other bit is pending (or the same channel re-queued), go to SERVE with a new winner and count=0.
    - Otherwise go to IDLE.
- **Round-robin.**
  - The search starts at `last+1` and wraps modulo N.
  - The first set pending bit wins. `last` is updated to the winner at each grant.
  - A pending bit that becomes set in the same cycle as arbitration is not visible until the next cycle.
- **Counter.** Width is $clog2(ACK_DELAY) (minimum 1). It never exceeds ACK_DELAY-1 and never wraps.
- **Registered outputs.** `ack` = (state==ACK) decoded by `grant_id`. `busy` = (state!=IDLE).
- **Reset values.**
  - state=IDLE, count=0, `pending`=0, `req_d1`=0.
  - `last`=N-1, so channel 0 wins first. `grant_id`=0.
  - `ack`=0, `overrun`=0, `busy`=0.
- **Reset mid-operation.** Any in-flight request is abandoned with no ack, and all pending bits are lost.
- **`req` held high through reset.** Because `req_d1` resets to 0, this produces a new edge in the first cycle after reset and counts as a request.

## Timing

- Let E0 be the clock edge at which `pos_edge[i]`=1 is sampled.
- **Idle arbiter.**
  - `pending[i]`=1 after E0.
  - SERVE with count=0 after E1.
  - ACK state after E(ACK_DELAY+1).
  - `ack[i]` is high during the cycle following E(ACK_DELAY+1), i.e. after E6 for the default.
- **Back-to-back service.** Consecutive ack pulses are exactly ACK_DELAY+1 cycles apart (6 by default). There is no idle gap.
- **Throughput.** Maximum one ack per ACK_DELAY+1 cycles.
- **Worst-case latency.** For a pending request this is N·(ACK_DELAY+1)+1 cycles.
- **`grant_id`.** Changes only on the edge entering SERVE and is stable through SERVE and ACK.
- **Simultaneous edges.** Edges on several channels in one cycle are all captured. They are served in round-robin order.

## Test plan

- **Single request.** Reset, then raise `req[0]` at E0 and hold it.
  - `ack`=4'b0001 for exactly one cycle after E6.
  - `grant_id`=0.
  - `busy` high from after E1 through the ack cycle.
- **Simultaneous requests.** From reset, raise `req[0]` and `req[2]` together.
  - `ack[0]` pulses after E6 and `ack[2]` after E12.
  - No other ack pulses.
- **Round-robin fairness.** Toggle `req[1]` every 20 cycles and `req[3]` every 20 cycles, starting with last grant = 1.
  - Grants alternate 3, 1, 3, 1.
  - No channel is granted twice while the other is pending.
- **Overrun.** Pulse `req[1]` 0→1→0→1 within 4 cycles while the arbiter is busy serving channel 2.
  - `overrun[1]` pulses once.
  - Only one `ack[1]` is issued.
- **Re-queue on own ack.** Raise `req[0]` again exactly in its ACK cycle.
  - A second `ack[0]` follows 6 cycles later.
  - `overrun` stays 0.
- **Reset mid-SERVE.** Assert `rst` for 1 cycle at count=3 while `req[0]` is held high.
  - No ack for the aborted request.
  - A fresh `ack[0]` arrives 7 cycles after `rst` deasserts, i.e. E0 is the first post-reset edge.
